// File: rtl/coin_key_debouncer_pkg.sv
// Shared constants and types for the coin key debouncer.
// Holds the coin values, the coin value width and the per-key debounce FSM states.
// Optional feature macro used by this slice: KEY_REPEAT_EN (auto-repeat while held).
package coin_pkg;

  localparam int unsigned COIN_W = 5;

  localparam logic [COIN_W-1:0] COIN_VAL_KEY0 = COIN_W'(5);
  localparam logic [COIN_W-1:0] COIN_VAL_KEY1 = COIN_W'(10);

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_REL_WAIT
  } db_state_e;

endpackage

// File: rtl/coin_key_debouncer_if.sv
// Coin event valid/ready channel between the debouncer and the coin accumulator.
//   coin_valid  coin event available
//   coin_value  coin value (5 or 10), 0 when coin_valid is low
//   coin_ready  consumer accepts the event when coin_valid && coin_ready
// master = event producer, slave = event consumer.
interface coin_key_debouncer_if;
  import coin_pkg::*;

  logic              coin_valid;
  logic [COIN_W-1:0] coin_value;
  logic              coin_ready;

  modport master (output coin_valid, output coin_value, input coin_ready);
  modport slave  (input coin_valid, input coin_value, output coin_ready);

endinterface

// File: rtl/coin_key_debouncer_key_debounce.sv
// Single-key conditioner: two-flop synchroniser, debounce FSM with a stability
// counter, and a one-cycle press strobe when a press is accepted.
// Optional feature macro: KEY_REPEAT_EN adds an auto-repeat strobe while held.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   key_n       raw key, active-low, asynchronous
//   level       debounced pressed level, active-high (registered)
//   press_c     press strobe, combinational, valid in the cycle before the accepting edge
module key_debounce import coin_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
`ifdef KEY_REPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = 25000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;

`ifdef KEY_REPEAT_EN
  localparam int unsigned      REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // Synchroniser on the inverted key so a 1 means pressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], ~key_n};
  end

  assign s = sync_q[1];

  // State, counter and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      level   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
`ifdef KEY_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // Next state, counter update and press strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_c = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = '0;
`endif

    unique case (state_q)
      DB_IDLE: begin
        if (s) state_d = DB_PRESS_WAIT;
      end
      DB_PRESS_WAIT: begin
        if (!s) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_PRESSED;
          press_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DB_PRESSED: begin
        if (!s) state_d = DB_REL_WAIT;
      end
      DB_REL_WAIT: begin
        if (s) begin
          state_d = DB_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = DB_IDLE;
    endcase

    // Every state change restarts the stability count
    if (state_d != state_q) cnt_d = '0;

`ifdef KEY_REPEAT_EN
    // Repeat timer runs only while staying in PRESSED
    if (state_q == DB_PRESSED && state_d == DB_PRESSED) begin
      if (rep_q == REP_LAST) press_c = 1'b1;
      else                   rep_d   = rep_q + REP_W'(1);
    end
`endif

    level_d = (state_d == DB_PRESSED) || (state_d == DB_REL_WAIT);
  end

endmodule

// File: rtl/coin_key_debouncer.sv
// Coin key front end: debounces the two raw active-low coin keys and turns each
// accepted press into one coin event (key0 = 5, key1 = 10) on a valid/ready channel.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat events while a key is held).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   key0, key1  raw active-low keys (5-unit, 10-unit coin)
//   coin        valid/ready coin event channel (master side)
//   key_level   debounced pressed level {key1, key0}
//   coin_drop   one-cycle pulse when a press is lost because that key's event is still pending
module coin_key_debouncer import coin_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
`ifdef KEY_REPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = 25000000
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key0,
  input  logic                        key1,
  coin_key_debouncer_if.master        coin,
  output logic [1:0]                  key_level,
  output logic                        coin_drop
);

  logic [1:0]        level, press_c;
  logic [1:0]        pend_q, pend_d, taken_c;
  logic              take_c, drop_c;
  logic              valid_q, valid_d;
  logic              sel_q, sel_d;
  logic [COIN_W-1:0] value_q, value_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
`ifdef KEY_REPEAT_EN
    , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
  ) u_key0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key0),
    .level   (level[0]),
    .press_c (press_c[0])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
`ifdef KEY_REPEAT_EN
    , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
  ) u_key1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key1),
    .level   (level[1]),
    .press_c (press_c[1])
  );

  assign key_level       = level;
  assign coin.coin_valid = valid_q;
  assign coin.coin_value = value_q;

  // Pending flags, drop detection and the output selector
  always_comb begin
    take_c  = valid_q & coin.coin_ready;
    taken_c = 2'b00;
    if (take_c) taken_c[sel_q] = 1'b1;

    // A pending flag covers the event on the output too; a press that meets a
    // same-key take simply re-arms the flag
    pend_d  = (pend_q & ~taken_c) | press_c;
    drop_c  = |(press_c & pend_q & ~taken_c);

    valid_d = valid_q;
    value_d = value_q;
    sel_d   = sel_q;

    if (!valid_q || take_c) begin
      if (pend_d[0]) begin
        valid_d = 1'b1;
        value_d = COIN_VAL_KEY0;
        sel_d   = 1'b0;
      end else if (pend_d[1]) begin
        valid_d = 1'b1;
        value_d = COIN_VAL_KEY1;
        sel_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
        value_d = '0;
        sel_d   = 1'b0;
      end
    end
  end

  // Output and pending registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 2'b00;
      valid_q   <= 1'b0;
      value_q   <= '0;
      sel_q     <= 1'b0;
      coin_drop <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      value_q   <= value_d;
      sel_q     <= sel_d;
      coin_drop <= drop_c;
    end
  end

endmodule

// File: tb/tb_coin_key_debouncer.sv
// Bench for coin_key_debouncer with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
// A behavioural model (run-length debounce, outstanding-event bits) is compared
// against the DUT on every falling edge; directed scenarios add literal checks.
module tb_coin_key_debouncer;

  localparam int D = 4;
  localparam int R = 20;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key0  = 1'b1;
  logic       key1  = 1'b1;
  logic [1:0] key_level;
  logic       coin_drop;

  int vectors     = 0;
  int miscompares = 0;

  coin_key_debouncer_if cif ();

  coin_key_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (4)
`ifdef KEY_REPEAT_EN
    , .REPEAT_CYCLES (R)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key0      (key0),
    .key1      (key1),
    .coin      (cif),
    .key_level (key_level),
    .coin_drop (coin_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  bit [1:0] pipe [2] = '{2'b00, 2'b00};   // synchroniser delay per key
  bit       lvl  [2] = '{1'b0, 1'b0};     // accepted level
  int       run  [2] = '{0, 0};           // consecutive samples disagreeing with lvl
  int       held [2] = '{0, 0};           // consecutive agreeing samples while pressed
  bit       outst[2] = '{1'b0, 1'b0};     // event outstanding per key
  bit       m_valid  = 1'b0;
  int       m_cur    = 0;
  bit       m_drop   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit press [2];
    bit tk    [2];
    bit raw   [2];
    bit s;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        pipe[k] = 2'b00; lvl[k] = 1'b0; run[k] = 0; held[k] = 0; outst[k] = 1'b0;
      end
      m_valid = 1'b0; m_cur = 0; m_drop = 1'b0;
    end else begin
      raw[0] = !key0;
      raw[1] = !key1;
      for (int k = 0; k < 2; k++) begin
        press[k] = 1'b0;
        s = pipe[k][1];
        if (s != lvl[k]) begin
          // a new level is accepted after D+1 consecutive disagreeing samples
          held[k] = 0;
          run[k]++;
          if (run[k] == D + 1) begin
            lvl[k]   = s;
            run[k]   = 0;
            press[k] = s;
          end
        end else if (run[k] != 0) begin
          run[k]  = 0;
          held[k] = 0;
        end else if (lvl[k]) begin
          held[k]++;
`ifdef KEY_REPEAT_EN
          if (held[k] == R) begin
            press[k] = 1'b1;
            held[k]  = 0;
          end
`endif
        end
        pipe[k] = {pipe[k][0], raw[k]};
      end
      for (int k = 0; k < 2; k++) tk[k] = m_valid && cif.coin_ready && (m_cur == k);
      m_drop = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (press[k] && outst[k] && !tk[k]) m_drop = 1'b1;
        outst[k] = (outst[k] && !tk[k]) || press[k];
      end
      if (!m_valid || tk[0] || tk[1]) begin
        if (outst[0])      begin m_valid = 1'b1; m_cur = 0; end
        else if (outst[1]) begin m_valid = 1'b1; m_cur = 1; end
        else               begin m_valid = 1'b0; m_cur = 0; end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("valid", int'(cif.coin_valid), int'(m_valid));
    chk("value", int'(cif.coin_value), m_valid ? ((m_cur == 0) ? 5 : 10) : 0);
    chk("key_level", int'(key_level), int'({lvl[1], lvl[0]}));
    chk("coin_drop", int'(coin_drop), int'(m_drop));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bit pat [15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int drops;
`ifdef KEY_REPEAT_EN
    int ev [$];
`endif
    cif.coin_ready = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("reset_valid", int'(cif.coin_valid), 0);
    chk("reset_value", int'(cif.coin_value), 0);
    chk("reset_level", int'(key_level), 0);
    chk("reset_drop", int'(coin_drop), 0);

    // 1: key0 low 10 cycles, event 6 edges after first low sample
    cif.coin_ready = 1'b1;
    key0 = 1'b0;
    step(6);
    chk("t1_not_yet", int'(cif.coin_valid), 0);
    step(1);
    chk("t1_valid", int'(cif.coin_valid), 1);
    chk("t1_value", int'(cif.coin_value), 5);
    chk("t1_level_hi", int'(key_level), 1);
    step(1);
    chk("t1_taken", int'(cif.coin_valid), 0);
    step(2);
    key0 = 1'b1;
    step(10);
    chk("t1_level_lo", int'(key_level), 0);

    // 2: bouncing key1 never settles long enough
    for (int i = 0; i < 15; i++) begin
      key1 = pat[i];
      step(1);
      chk("t2_valid", int'(cif.coin_valid), 0);
      chk("t2_drop", int'(coin_drop), 0);
    end

    // 3: both keys on the same edge, key0 first
    key0 = 1'b0;
    key1 = 1'b0;
    step(7);
    chk("t3_first_valid", int'(cif.coin_valid), 1);
    chk("t3_first_value", int'(cif.coin_value), 5);
    step(1);
    chk("t3_second_value", int'(cif.coin_value), 10);
    step(1);
    chk("t3_idle", int'(cif.coin_valid), 0);
    key0 = 1'b1;
    key1 = 1'b1;
    step(10);

    // 4: consumer stalled, second key0 press is dropped
    cif.coin_ready = 1'b0;
    drops = 0;
    key0 = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); if (coin_drop) drops++; end
    chk("t4_hold_valid", int'(cif.coin_valid), 1);
    chk("t4_hold_value", int'(cif.coin_value), 5);
    key0 = 1'b1;
    for (int i = 0; i < 10; i++) begin step(1); if (coin_drop) drops++; end
    key0 = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); if (coin_drop) drops++; end
    key0 = 1'b1;
    for (int i = 0; i < 10; i++) begin step(1); if (coin_drop) drops++; end
    chk("t4_drops", drops, 1);
    chk("t4_still_value", int'(cif.coin_value), 5);
    cif.coin_ready = 1'b1;
    step(1);
    chk("t4_one_event", int'(cif.coin_valid), 0);
    step(5);
    chk("t4_no_more", int'(cif.coin_valid), 0);

    // 5: reset during key0 debounce with a key1 event still on the output
    cif.coin_ready = 1'b0;
    key1 = 1'b0;
    step(8);
    key1 = 1'b1;
    step(8);
    chk("t5_pre_value", int'(cif.coin_value), 10);
    key0 = 1'b0;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(cif.coin_valid), 0);
    chk("t5_rst_value", int'(cif.coin_value), 0);
    chk("t5_rst_level", int'(key_level), 0);
    step(3);
    rst_n = 1'b1;
    cif.coin_ready = 1'b1;
    step(6);
    chk("t5_not_yet", int'(cif.coin_valid), 0);
    step(1);
    chk("t5_valid", int'(cif.coin_valid), 1);
    chk("t5_value", int'(cif.coin_value), 5);
    key0 = 1'b1;
    step(10);

`ifdef KEY_REPEAT_EN
    // 6: key1 held 70 cycles, events every 20 cycles
    key1 = 1'b0;
    for (int i = 1; i <= 75; i++) begin
      if (i == 71) key1 = 1'b1;
      step(1);
      if (cif.coin_valid && cif.coin_value == 5'd10) ev.push_back(i);
    end
    chk("t6_count", ev.size(), 4);
    if (ev.size() == 4) begin
      chk("t6_first", ev[0], 7);
      chk("t6_second", ev[1], 27);
      chk("t6_third", ev[2], 47);
      chk("t6_fourth", ev[3], 67);
    end
    step(10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
